// File: rtl/ctrl_pkg.sv
// Shared types for the 9-bit-ISA control sequencer: FSM states, opcode values
// and the decoded-instruction bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_MEMWR = 3'b110;
  localparam logic [2:0] OP_JUMP  = 3'b111;

  // halt marks the all-ones word; when it is set every other field is forced low
  typedef struct packed {
    logic halt;
    logic jump;
    logic branch;
    logic regwr;
    logic memwr;
    logic load;
    logic store;
  } decode_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Pure combinational instruction decode: IR word -> strobe bundle.
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] ir,
  output decode_t       dec
);

  logic [2:0] op;
  logic       halt;

  assign op   = ir[IW-1 -: 3];
  assign halt = &ir;

  always_comb begin
    dec      = '0;
    dec.halt = halt;
    // the halt word shares opcode 111 with jump but must not raise any strobe
    if (!halt) begin
      dec.jump   = (op == OP_JUMP);
      dec.branch = (op[2:1] == 2'b11);
      dec.regwr  = (op[2:1] != 2'b11) && (op != OP_STORE);
      dec.memwr  = (op == OP_MEMWR);
      dec.load   = (op == OP_LOAD);
      dec.store  = (op == OP_STORE);
    end
  end

endmodule

// File: rtl/ctrl_seq_decoder.sv
// Multi-cycle control sequencer: IR register, load wait counter and the
// fetch/execute FSM. Strobes are decoded combinationally from (state, IR).
//
//   state | meaning
//   IDLE  | waiting for Start after reset
//   FETCH | capture Instruction into IR
//   EXEC  | issue strobes for one cycle; loads continue into MEM
//   MEM   | load waiting on synchronous data memory
//   HALT  | halt word retired, Ack held until Start
module ctrl_seq_decoder
  import ctrl_pkg::*;
#(
  parameter int IW        = 9,
  parameter int TSW       = 2,
  parameter int LOAD_WAIT = 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [IW-1:0]  Instruction,
  output logic           PcEn,
  output logic           Jump,
  output logic           BranchEn,
  output logic           RegWrEn,
  output logic           MemWrEn,
  output logic           LoadInst,
  output logic           StoreInst,
  output logic [TSW-1:0] TargSel,
  output logic           Ack,
  output logic           Busy
);

  localparam int CW       = (LOAD_WAIT > 0) ? $clog2(LOAD_WAIT + 1) : 1;
  localparam bit HAS_WAIT = (LOAD_WAIT > 0);

  state_t        state;
  logic [IW-1:0] ir;
  logic [CW-1:0] cnt;
  decode_t       dec;

  ctrl_op_decode #(.IW(IW)) u_dec (
    .ir  (ir),
    .dec (dec)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (Start) state <= ST_FETCH;
        ST_FETCH: begin
          ir    <= Instruction;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.halt) begin
            state <= ST_HALT;
          end else if (dec.load && HAS_WAIT) begin
            state <= ST_MEM;
            cnt   <= CW'(LOAD_WAIT - 1);
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= ST_FETCH;
        end
        ST_HALT:  if (Start) state <= ST_FETCH;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    PcEn      = 1'b0;
    Jump      = 1'b0;
    BranchEn  = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    LoadInst  = 1'b0;
    StoreInst = 1'b0;
    TargSel   = ir[IW-4 -: TSW];
    Busy      = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MEM);
    // Ack releases in the same cycle Start is seen so the host sees a clean handshake
    Ack       = (state == ST_HALT) && !Start;
    case (state)
      ST_EXEC: begin
        if (!dec.halt) begin
          if (dec.load) begin
            LoadInst = 1'b1;
            if (!HAS_WAIT) begin
              RegWrEn = 1'b1;
              PcEn    = 1'b1;
            end
          end else begin
            PcEn      = 1'b1;
            Jump      = dec.jump;
            BranchEn  = dec.branch;
            RegWrEn   = dec.regwr;
            MemWrEn   = dec.memwr;
            StoreInst = dec.store;
          end
        end
      end
      ST_MEM: begin
        LoadInst = 1'b1;
        if (cnt == '0) begin
          RegWrEn = 1'b1;
          PcEn    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// Bench for ctrl_seq_decoder: two instances (LOAD_WAIT=2 and 3) share stimulus and
// are checked every cycle against an instruction-level model, plus literal checkpoints.
module tb_ctrl_seq_decoder;

  localparam logic [8:0] PCEN   = 9'h100;
  localparam logic [8:0] JUMP   = 9'h080;
  localparam logic [8:0] BRANCH = 9'h040;
  localparam logic [8:0] REGWR  = 9'h020;
  localparam logic [8:0] MEMWR  = 9'h010;
  localparam logic [8:0] LOAD   = 9'h008;
  localparam logic [8:0] STORE  = 9'h004;
  localparam logic [8:0] ACK    = 9'h002;
  localparam logic [8:0] BUSY   = 9'h001;

  localparam int M_IDLE = 0, M_FETCH = 1, M_RUN = 2, M_HALT = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Instruction = 9'h000;

  logic       a_PcEn, a_Jump, a_BranchEn, a_RegWrEn, a_MemWrEn, a_LoadInst, a_StoreInst, a_Ack, a_Busy;
  logic       b_PcEn, b_Jump, b_BranchEn, b_RegWrEn, b_MemWrEn, b_LoadInst, b_StoreInst, b_Ack, b_Busy;
  logic [1:0] a_ts, b_ts;
  logic [8:0] a_vec, b_vec;

  int         nchk = 0;
  int         nerr = 0;
  logic       chk_en = 1'b0;

  int         mode [2];
  logic [8:0] irm  [2];
  int         step [2];
  int         lw   [2];
  logic [8:0] exp_v  [2];
  logic [1:0] exp_ts [2];

  always #5 Clk = ~Clk;

  ctrl_seq_decoder #(.IW(9), .TSW(2), .LOAD_WAIT(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .PcEn(a_PcEn), .Jump(a_Jump), .BranchEn(a_BranchEn), .RegWrEn(a_RegWrEn),
    .MemWrEn(a_MemWrEn), .LoadInst(a_LoadInst), .StoreInst(a_StoreInst),
    .TargSel(a_ts), .Ack(a_Ack), .Busy(a_Busy)
  );

  ctrl_seq_decoder #(.IW(9), .TSW(2), .LOAD_WAIT(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .PcEn(b_PcEn), .Jump(b_Jump), .BranchEn(b_BranchEn), .RegWrEn(b_RegWrEn),
    .MemWrEn(b_MemWrEn), .LoadInst(b_LoadInst), .StoreInst(b_StoreInst),
    .TargSel(b_ts), .Ack(b_Ack), .Busy(b_Busy)
  );

  assign a_vec = {a_PcEn, a_Jump, a_BranchEn, a_RegWrEn, a_MemWrEn, a_LoadInst, a_StoreInst, a_Ack, a_Busy};
  assign b_vec = {b_PcEn, b_Jump, b_BranchEn, b_RegWrEn, b_MemWrEn, b_LoadInst, b_StoreInst, b_Ack, b_Busy};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_load(input logic [8:0] ir);
    return (ir != 9'h1FF) && (ir[8:6] == 3'b011);
  endfunction

  // Expected outputs for execute-phase step k (0 = EXEC, k>=1 = k-th memory wait cycle)
  function automatic logic [8:0] exec_vec(input logic [8:0] ir, input int k, input int w);
    logic [2:0] op;
    logic [8:0] v;
    op = ir[8:6];
    v  = BUSY;
    if (ir == 9'h1FF) return v;
    if (is_load(ir)) begin
      v |= LOAD;
      if (k == w) v |= PCEN | REGWR;
      return v;
    end
    v |= PCEN;
    if (op == 3'd7) v |= JUMP;
    if (op >= 3'd6) v |= BRANCH;
    if (op == 3'd6) v |= MEMWR;
    if (op == 3'd5) v |= STORE;
    if (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4) v |= REGWR;
    return v;
  endfunction

  function automatic int exec_len(input logic [8:0] ir, input int w);
    return is_load(ir) ? w + 1 : 1;
  endfunction

  // Expected outputs for the current cycle from the current inputs, then advance.
  task automatic model_step(input int k);
    exp_ts[k] = irm[k][5:4];
    if (Reset) begin
      mode[k]   = M_IDLE;
      irm[k]    = 9'h000;
      exp_v[k]  = 9'h000;
      exp_ts[k] = 2'b00;
      return;
    end
    case (mode[k])
      M_IDLE: begin
        exp_v[k] = 9'h000;
        if (Start) mode[k] = M_FETCH;
      end
      M_HALT: begin
        exp_v[k] = Start ? 9'h000 : ACK;
        if (Start) mode[k] = M_FETCH;
      end
      M_FETCH: begin
        exp_v[k] = BUSY;
        irm[k]   = Instruction;
        step[k]  = 0;
        mode[k]  = M_RUN;
      end
      default: begin
        exp_v[k] = exec_vec(irm[k], step[k], lw[k]);
        step[k]++;
        if (step[k] >= exec_len(irm[k], lw[k]))
          mode[k] = (irm[k] == 9'h1FF) ? M_HALT : M_FETCH;
      end
    endcase
  endtask

  task automatic cyc(input logic r, input logic s, input logic [8:0] ins);
    @(posedge Clk);
    #1;
    Reset       = r;
    Start       = s;
    Instruction = ins;
    model_step(0);
    model_step(1);
    chk_en = 1'b1;
    @(negedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("a_outputs", 16'(a_vec), 16'(exp_v[0]));
      chk("a_targsel", 16'(a_ts),  16'(exp_ts[0]));
      chk("b_outputs", 16'(b_vec), 16'(exp_v[1]));
      chk("b_targsel", 16'(b_ts),  16'(exp_ts[1]));
    end
  end

  initial begin
    logic [8:0] ins;
    logic       r, s;
    lw[0] = 2;
    lw[1] = 3;
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE; irm[k] = 9'h000; step[k] = 0; exp_v[k] = 9'h000; exp_ts[k] = 2'b00;
    end

    // reset, then a plain register-writing instruction
    cyc(1'b1, 1'b0, 9'h000);
    cyc(1'b1, 1'b0, 9'h000);
    chk("reset_a_out", 16'(a_vec), 16'h0000);
    chk("reset_b_out", 16'(b_vec), 16'h0000);
    chk("reset_a_ts",  16'(a_ts),  16'h0000);
    cyc(1'b0, 1'b0, 9'h000);
    chk("idle_a_out", 16'(a_vec), 16'h0000);
    cyc(1'b0, 1'b1, 9'h000);
    cyc(1'b0, 1'b0, 9'b000_01_0000);
    chk("fetch_busy", 16'(a_vec), 16'h0001);
    cyc(1'b0, 1'b0, 9'b011_10_0000);
    chk("alu_exec_a", 16'(a_vec), 16'h0121);
    chk("alu_exec_b", 16'(b_vec), 16'h0121);
    chk("alu_ts",     16'(a_ts),  16'h0001);

    // load with LOAD_WAIT=2 on instance a
    cyc(1'b0, 1'b0, 9'b011_10_0000);
    cyc(1'b0, 1'b0, 9'b011_10_0000);
    chk("load_exec", 16'(a_vec), 16'h0009);
    chk("load_ts",   16'(a_ts),  16'h0002);
    cyc(1'b0, 1'b0, 9'b011_10_0000);
    chk("load_mem1", 16'(a_vec), 16'h0009);
    cyc(1'b0, 1'b0, 9'b101_00_0000);
    chk("load_mem2", 16'(a_vec), 16'h0129);
    chk("load_b_mem2_wait", 16'(b_vec), 16'h0009);

    // store then memory-write/branch pair
    cyc(1'b0, 1'b0, 9'b101_00_0000);
    chk("load_b_mem3", 16'(b_vec), 16'h0129);
    cyc(1'b0, 1'b0, 9'b110_00_0000);
    chk("store_exec", 16'(a_vec), 16'h0105);
    cyc(1'b0, 1'b0, 9'b110_00_0000);
    cyc(1'b0, 1'b0, 9'h1FF);
    chk("memwr_exec", 16'(a_vec), 16'h0151);

    // halt word: no jump, sticky Ack, restart by Start
    cyc(1'b0, 1'b0, 9'h1FF);
    cyc(1'b0, 1'b0, 9'h000);
    chk("halt_exec", 16'(a_vec), 16'h0001);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 9'h000);
      chk("halt_ack", 16'(a_vec), 16'h0002);
    end
    cyc(1'b0, 1'b1, 9'h000);
    chk("halt_start_ack_a", 16'(a_vec), 16'h0000);
    chk("halt_start_ack_b", 16'(b_vec), 16'h0000);
    cyc(1'b0, 1'b0, 9'b001_11_0000);
    chk("restart_fetch", 16'(a_vec), 16'h0001);

    // Start during EXEC is ignored
    cyc(1'b0, 1'b1, 9'h000);
    chk("start_in_exec", 16'(a_vec), 16'h0121);
    chk("start_in_exec_ts", 16'(a_ts), 16'h0003);
    cyc(1'b0, 1'b0, 9'h000);
    chk("after_start_fetch", 16'(a_vec), 16'h0001);
    cyc(1'b0, 1'b0, 9'h000);
    chk("after_start_exec", 16'(a_vec), 16'h0121);

    // reset in the second wait cycle of a LOAD_WAIT=3 load
    cyc(1'b1, 1'b0, 9'h000);
    cyc(1'b0, 1'b1, 9'h000);
    cyc(1'b0, 1'b0, 9'b011_01_0000);
    cyc(1'b0, 1'b0, 9'b011_01_0000);
    cyc(1'b0, 1'b0, 9'b011_01_0000);
    chk("b_mem1", 16'(b_vec), 16'h0009);
    cyc(1'b1, 1'b0, 9'b011_01_0000);
    chk("b_mem2_reset", 16'(b_vec), 16'h0000);
    chk("b_mem2_reset_ts", 16'(b_ts), 16'h0000);
    cyc(1'b1, 1'b0, 9'h000);
    cyc(1'b0, 1'b0, 9'h000);
    chk("b_idle_after_reset", 16'(b_vec), 16'h0000);
    cyc(1'b0, 1'b0, 9'h000);
    chk("b_idle_after_reset2", 16'(b_vec), 16'h0000);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      ins = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom);
      cyc(r, s, ins);
    end

    chk_en = 1'b0;
    @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
